// File: rtl/life_grid_ctrl.sv
// life_grid_ctrl: command sequencer that loads, steps and reads back a WIDTH x HEIGHT life-cell array
//   host side : cmd_valid/cmd_ready/cmd_op/cmd_gens, ld_valid/ld_ready/ld_data, rd_valid/rd_ready/rd_bit, busy, done
//   array side: run, load_in (one-hot row), in_data, load_out, shift, chain_out (tail of the out chain)
//   clk, reset (synchronous, active-low)
module life_grid_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [GEN_W-1:0]  cmd_gens,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_bit,
    output logic              busy,
    output logic              done,
    output logic              run,
    output logic [HEIGHT-1:0] load_in,
    output logic [WIDTH-1:0]  in_data,
    output logic              load_out,
    output logic              shift,
    input  logic              chain_out
);
    localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int BW = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH * HEIGHT - 1);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, SHIFT, FIN} state_t;
    state_t state, state_n;
    logic [RW-1:0] row;
    logic [BW-1:0] bitcnt;
    logic [GEN_W-1:0] gens;
    logic accept, ld_hs, rd_hs;
    always_comb begin
        accept  = cmd_valid && state == IDLE;
        ld_hs   = ld_valid && state == LOAD;
        rd_hs   = rd_ready && state == SHIFT;
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = cmd_op == 2'b00 ? LOAD :
                                           cmd_op == 2'b10 ? CAPTURE :
                                           (cmd_op == 2'b01 && cmd_gens != '0) ? RUN : FIN;
            LOAD:    if (ld_hs && row == ROW_LAST) state_n = FIN;
            RUN:     if (gens <= GEN_W'(1)) state_n = FIN;
            CAPTURE: state_n = SHIFT;
            SHIFT:   if (rd_hs && bitcnt == BIT_LAST) state_n = FIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            row    <= '0;
            bitcnt <= '0;
            gens   <= '0;
            run    <= 1'b0;
        end else begin
            state  <= state_n;
            run    <= state_n == RUN;
            row    <= state == IDLE ? '0 : ld_hs ? row + RW'(1) : row;
            bitcnt <= state == CAPTURE ? '0 : rd_hs ? bitcnt + BW'(1) : bitcnt;
            gens   <= accept ? cmd_gens : (state == RUN && gens != '0) ? gens - GEN_W'(1) : gens;
        end
    end
    // strobes are masked while reset is asserted so an abort issues nothing further to the array
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign ld_ready  = state == LOAD;
    assign rd_valid  = state == SHIFT;
    assign rd_bit    = chain_out;
    assign done      = reset && state == FIN;
    assign load_in   = (reset && ld_hs) ? HEIGHT'(1) << row : '0;
    assign in_data   = (reset && ld_hs) ? ld_data : '0;
    assign load_out  = reset && state == CAPTURE;
    assign shift     = reset && rd_hs;
endmodule

// File: tb/tb_life_grid_ctrl.sv
// tb_life_grid_ctrl: directed bench for life_grid_ctrl driving a 4x4 behavioural life array
module tb_life_grid_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam logic [W-1:0] GL [H] = '{4'b0010, 4'b0100, 4'b0111, 4'b0000};

    logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, ld_valid = 1'b0, rd_ready = 1'b0;
    logic [1:0] cmd_op = 2'b11;
    logic [15:0] cmd_gens = '0;
    logic [W-1:0] ld_data = '0;
    logic cmd_ready, ld_ready, rd_valid, rd_bit, busy, done, run, load_out, shift, chain_out;
    logic [H-1:0] load_in;
    logic [W-1:0] in_data;

    always #5 clk = ~clk;

    life_grid_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_gens(cmd_gens), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bit(rd_bit), .busy(busy), .done(done),
        .run(run), .load_in(load_in), .in_data(in_data), .load_out(load_out), .shift(shift),
        .chain_out(chain_out)
    );

    // behavioural cell array, dead cells beyond the edges; chain tail is cell (row 0, col 0)
    logic [N-1:0] g = '0, chain = '0;
    function automatic logic [N-1:0] life(input logic [N-1:0] s);
        logic [N-1:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                            n += int'(s[(r + dr) * W + c + dc]);
                nx[r * W + c] = s[r * W + c] ? (n == 2 || n == 3) : (n == 3);
            end
        return nx;
    endfunction
    always @(posedge clk) begin
        if (run) g <= life(g);
        for (int r = 0; r < H; r++) if (load_in[r]) g[r * W +: W] <= in_data;
        if (load_out) chain <= g;
        else if (shift) chain <= chain >> 1;
    end
    assign chain_out = chain[0];

    int checks = 0, failures = 0;
    int run_cnt = 0, li_cnt = 0, lo_cnt = 0, sh_cnt = 0, done_cnt = 0;
    logic [H+W-1:0] q_li [$];
    logic q_bit [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        run_cnt  += int'(run);
        li_cnt   += int'(|load_in);
        lo_cnt   += int'(load_out);
        sh_cnt   += int'(shift);
        done_cnt += int'(done);
        if (reset) begin
            chk("strobe_mutex", 32'($countones({run, |load_in, load_out, shift}) <= 1), 32'd1);
            chk("shift_eq_handshake", 32'(shift), 32'(rd_valid && rd_ready));
            if (load_in == '0) chk("in_data_idle", 32'(in_data), 32'd0);
            else if (q_li.size() == 0) chk("load_in_unexpected", 32'(q_li.size()), 32'd1);
            else chk("load_in_row", 32'({load_in, in_data}), 32'(q_li.pop_front()));
            if (rd_valid && rd_ready) begin
                if (q_bit.size() == 0) chk("rd_unexpected", 32'(q_bit.size()), 32'd1);
                else chk("rd_bit", 32'(rd_bit), 32'(q_bit.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] gens);
        int i;
        i = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_gens = gens;
        while (!cmd_ready && i < 100) begin tick(); i++; end
        if (i == 100) chk("cmd_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_gens = 16'($urandom);
    endtask

    task automatic push_bits(input bit moved);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                q_bit.push_back(moved ? ((r > 0 && c > 0) ? GL[r-1][c-1] : 1'b0) : GL[r][c]);
    endtask

    task automatic drain(input int limit, input bit rnd);
        int i;
        i = 0;
        while (q_bit.size() > 0 && i < limit) begin
            if (rnd) rd_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        chk("read_drained", 32'(q_bit.size()), 32'd0);
    endtask

    int d0, r0, l0, s0, o0;
    initial begin
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_in", 32'(load_in), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        reset = 1'b1;
        tick();
        // abort a long RUN with a two-cycle reset
        issue(2'b01, 16'd100);
        tick(); tick(); tick();
        chk("run_mid", 32'(run), 32'd1);
        d0 = done_cnt;
        reset = 1'b0;
        tick();
        chk("abort_run", 32'(run), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_run_after", 32'(run), 32'd0);
        // gapped glider load
        d0 = done_cnt; l0 = li_cnt;
        issue(2'b00, 16'd0);
        for (int r = 0; r < H; r++) begin
            ld_valid = 1'b1;
            ld_data = GL[r];
            q_li.push_back({4'(1 << r), GL[r]});
            tick();
            ld_valid = 1'b0;
            ld_data = '0;
            tick();
        end
        tick();
        chk("load_pulses", 32'(li_cnt - l0), 32'd4);
        chk("load_queue", 32'(q_li.size()), 32'd0);
        chk("load_done", 32'(done_cnt - d0), 32'd1);
        chk("load_idle", 32'(cmd_ready), 32'd1);
        // four generations move the glider by (+1,+1)
        d0 = done_cnt; r0 = run_cnt;
        issue(2'b01, 16'd4);
        for (int i = 0; i < 8; i++) tick();
        chk("run4_pulses", 32'(run_cnt - r0), 32'd4);
        chk("run4_done", 32'(done_cnt - d0), 32'd1);
        d0 = done_cnt; s0 = sh_cnt; o0 = lo_cnt;
        push_bits(1'b1);
        rd_ready = 1'b1;
        issue(2'b10, 16'd0);
        drain(100, 1'b0);
        tick(); tick();
        chk("read1_shifts", 32'(sh_cnt - s0), 32'd16);
        chk("read1_load_out", 32'(lo_cnt - o0), 32'd1);
        chk("read1_done", 32'(done_cnt - d0), 32'd1);
        // zero-generation RUN and NOP finish straight away
        d0 = done_cnt; r0 = run_cnt;
        issue(2'b01, 16'd0);
        chk("gens0_done", 32'(done), 32'd1);
        chk("gens0_run", 32'(run), 32'd0);
        tick();
        chk("gens0_done_end", 32'(done), 32'd0);
        chk("gens0_idle", 32'(cmd_ready), 32'd1);
        issue(2'b11, 16'd0);
        chk("nop_done", 32'(done), 32'd1);
        tick();
        chk("nop_done_end", 32'(done), 32'd0);
        chk("gens0_nop_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("gens0_no_run", 32'(run_cnt - r0), 32'd0);
        // READ with a stalled then randomly toggling consumer
        d0 = done_cnt; s0 = sh_cnt; o0 = lo_cnt;
        push_bits(1'b1);
        rd_ready = 1'b0;
        issue(2'b10, 16'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        chk("stall_no_shift", 32'(sh_cnt - s0), 32'd0);
        drain(400, 1'b1);
        rd_ready = 1'b0;
        tick(); tick();
        chk("read2_shifts", 32'(sh_cnt - s0), 32'd16);
        chk("read2_load_out", 32'(lo_cnt - o0), 32'd1);
        chk("read2_done", 32'(done_cnt - d0), 32'd1);
        // commands held during LOAD wait for the current one to finish
        d0 = done_cnt; l0 = li_cnt;
        issue(2'b00, 16'd0);
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        for (int r = 0; r < H; r++) begin
            ld_valid = 1'b1;
            ld_data = GL[r];
            q_li.push_back({4'(1 << r), GL[r]});
            chk("held_load_not_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        ld_valid = 1'b0;
        ld_data = '0;
        chk("held_load_fin", 32'(done), 32'd1);
        tick(); tick();
        cmd_valid = 1'b0;
        tick();
        chk("held_load_pulses", 32'(li_cnt - l0), 32'd4);
        chk("held_load_done", 32'(done_cnt - d0), 32'd2);
        chk("held_load_idle", 32'(cmd_ready), 32'd1);
        // and during SHIFT; the grid now holds the unmoved glider
        d0 = done_cnt; s0 = sh_cnt;
        push_bits(1'b0);
        rd_ready = 1'b1;
        issue(2'b10, 16'd0);
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        for (int i = 0; i < 40 && q_bit.size() > 0; i++) begin
            chk("held_shift_not_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        chk("read3_drained", 32'(q_bit.size()), 32'd0);
        tick(); tick();
        cmd_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        chk("read3_shifts", 32'(sh_cnt - s0), 32'd16);
        chk("held_shift_done", 32'(done_cnt - d0), 32'd2);
        chk("final_idle", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
